// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scanner: synced scan_clk ticks step through
// double-buffered hex digits, with a one-cycle blanking gap between them.
// Ports: clk, reset (async, low), scan_clk, enable, digits_in, dp_in,
//   blank_in, load -> load_ack, anode_n, seg_n, dp_n, digit_idx, frame_done.
module display_scan_controller #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_clk,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic s1_q, s2_q, p_q;
  logic [1:0] state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic [4*DIGITS-1:0] sh_dig_q;
  logic [DIGITS-1:0] sh_dp_q, sh_blk_q;

  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;
  logic [IDX_W-1:0] didx_q;
  logic fd_q, ack_q;

  logic tick, last, wrap, req, wr;
  logic [3:0] cur_nib;
  logic cur_dp, cur_blk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = s2_q & ~p_q;
  assign last = (idx_q == IDX_W'(DIGITS - 1));
  assign wrap = enable && (state_q == ST_DRIVE) && tick && last;
  assign req  = pend_q | load;
  // OFF applies loads at once; otherwise only at the frame wrap
  assign wr   = req && ((state_q == ST_OFF) || wrap);

  assign cur_nib = 4'(sh_dig_q >> {idx_q, 2'b00});
  assign cur_dp  = 1'(sh_dp_q >> idx_q);
  assign cur_blk = 1'(sh_blk_q >> idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_DRIVE;
          idx_d   = '0;
        end
        ST_DRIVE: begin
          if (tick) begin
            state_d = ST_GAP;
            idx_d   = last ? '0 : idx_q + IDX_W'(1);
          end
        end
        ST_GAP:  state_d = ST_DRIVE;
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign pend_d = wr ? 1'b0 : req;

  // outputs are registered from the current state, one cycle behind it
  always_comb begin
    anode_d = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == ST_DRIVE) begin
      anode_d = ~(DIGITS'(1) << idx_q);
      if (!cur_blk) begin
        seg_d = hex7(cur_nib);
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      p_q      <= 1'b0;
      state_q  <= ST_OFF;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_blk_q <= '0;
      anode_q  <= '1;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      didx_q   <= '0;
      fd_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      s1_q    <= scan_clk;
      s2_q    <= s1_q;
      p_q     <= s2_q;
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (wr) begin
        sh_dig_q <= digits_in;
        sh_dp_q  <= dp_in;
        sh_blk_q <= blank_in;
      end
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      didx_q  <= idx_q;
      fd_q    <= wrap;
      ack_q   <= wr;
    end
  end

  assign anode_n    = anode_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign digit_idx  = didx_q;
  assign frame_done = fd_q;
  assign load_ack   = ack_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (DIGITS=4):
// reset, scan order, deferred/coincident loads, blank/dp, enable drop.
module tb_display_scan_controller;

  logic clk = 1'b0;
  logic reset;
  logic scan_clk;
  logic enable;
  logic [15:0] digits_in;
  logic [3:0] dp_in, blank_in;
  logic load;
  logic load_ack;
  logic [3:0] anode_n;
  logic [6:0] seg_n;
  logic dp_n;
  logic [2:0] digit_idx;
  logic frame_done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.DIGITS(4), .IDX_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .scan_clk(scan_clk),
    .enable(enable),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .blank_in(blank_in),
    .load(load),
    .load_ack(load_ack),
    .anode_n(anode_n),
    .seg_n(seg_n),
    .dp_n(dp_n),
    .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_anode"}, 32'(anode_n), 'hF);
    chk({tag, "_seg"}, 32'(seg_n), 'h7F);
    chk({tag, "_dp"}, 32'(dp_n), 1);
    chk({tag, "_idx"}, 32'(digit_idx), 0);
  endtask

  task automatic chk_drive(input int an, input int sg,
                           input int dp, input int ix);
    chk("anode", 32'(anode_n), an);
    chk("seg", 32'(seg_n), sg);
    chk("dp", 32'(dp_n), dp);
    chk("idx", 32'(digit_idx), ix);
  endtask

  // one scan_clk rise: gap cycle, then the next digit
  task automatic adv(input bit ld, input logic [15:0] dat,
                     input int an, input int sg, input int dp,
                     input int ix, input int fd, input int ack);
    scan_clk = 1'b1;
    step();
    step();
    if (ld) begin
      digits_in = dat;
      load = 1'b1;
    end
    step();
    load = 1'b0;
    chk("frame_done", 32'(frame_done), fd);
    chk("load_ack", 32'(load_ack), ack);
    step();
    chk("gap_anode", 32'(anode_n), 'hF);
    chk("gap_seg", 32'(seg_n), 'h7F);
    chk("gap_idx", 32'(digit_idx), ix);
    scan_clk = 1'b0;
    step();
    step();
    chk_drive(an, sg, dp, ix);
    chk("fd_clear", 32'(frame_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    scan_clk = 1'(($urandom));
    enable = 1'(($urandom));
    digits_in = 16'($urandom);
    dp_in = 4'($urandom);
    blank_in = 4'($urandom);
    load = 1'(($urandom));
    step();
    scan_clk = ~scan_clk;
    load = ~load;
    step();
    chk_off("rst");
    chk("rst_fd", 32'(frame_done), 0);
    chk("rst_ack", 32'(load_ack), 0);

    scan_clk = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    dp_in = '0;
    blank_in = '0;
    digits_in = 16'h1234;
    reset = 1'b1;
    step();
    step();
    step();
    chk_off("post_rst");
    chk("post_rst_fd", 32'(frame_done), 0);
    chk("post_rst_ack", 32'(load_ack), 0);

    load = 1'b1;
    step();
    load = 1'b0;
    chk("off_load_ack", 32'(load_ack), 1);
    step();
    chk("off_ack_clr", 32'(load_ack), 0);

    enable = 1'b1;
    step();
    chk_off("en_lat");
    step();
    chk_drive('hE, 'h19, 1, 0);

    adv(0, '0, 'hD, 'h30, 1, 1, 0, 0);
    adv(0, '0, 'hB, 'h24, 1, 2, 0, 0);
    adv(0, '0, 'h7, 'h79, 1, 3, 0, 0);
    adv(0, '0, 'hE, 'h19, 1, 0, 1, 0);

    adv(0, '0, 'hD, 'h30, 1, 1, 0, 0);
    digits_in = 16'hABCD;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("defer_ack", 32'(load_ack), 0);
    adv(0, '0, 'hB, 'h24, 1, 2, 0, 0);
    adv(0, '0, 'h7, 'h79, 1, 3, 0, 0);
    adv(0, '0, 'hE, 'h21, 1, 0, 1, 1);
    adv(0, '0, 'hD, 'h46, 1, 1, 0, 0);
    adv(0, '0, 'hB, 'h03, 1, 2, 0, 0);
    adv(0, '0, 'h7, 'h08, 1, 3, 0, 0);

    adv(1, 16'h5678, 'hE, 'h00, 1, 0, 1, 1);
    digits_in = 16'h9999;
    adv(0, '0, 'hD, 'h78, 1, 1, 0, 0);
    adv(0, '0, 'hB, 'h02, 1, 2, 0, 0);
    adv(0, '0, 'h7, 'h12, 1, 3, 0, 0);
    adv(0, '0, 'hE, 'h00, 1, 0, 1, 0);

    blank_in = 4'b0100;
    dp_in = 4'b0001;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("bdp_ack", 32'(load_ack), 0);
    adv(0, '0, 'hD, 'h78, 1, 1, 0, 0);
    adv(0, '0, 'hB, 'h02, 1, 2, 0, 0);
    adv(0, '0, 'h7, 'h12, 1, 3, 0, 0);
    adv(0, '0, 'hE, 'h10, 0, 0, 1, 1);
    adv(0, '0, 'hD, 'h10, 1, 1, 0, 0);
    adv(0, '0, 'hB, 'h7F, 1, 2, 0, 0);

    enable = 1'b0;
    step();
    step();
    chk_off("drop");
    scan_clk = 1'b1;
    step();
    step();
    step();
    step();
    chk_off("off_tick");
    chk("off_tick_fd", 32'(frame_done), 0);

    enable = 1'b1;
    step();
    chk_off("reen_lat");
    step();
    chk_drive('hE, 'h10, 0, 0);
    step();
    step();
    step();
    chk_drive('hE, 'h10, 0, 0);
    scan_clk = 1'b0;
    step();
    step();
    step();
    chk_drive('hE, 'h10, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
